reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file.sv | 91 +++++++++
 tb/tb_reg_file.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// reg_file: 2**ADDR_WIDTH x DATA_WIDTH register file with one write port and
// two combinational read ports. Entry 0 is hardwired to zero.
// Optional build macro: REG_FILE_BYPASS_EN forwards wd3 to a read port that
// addresses the register being written in the same cycle.

// One storage word. Clears on synchronous reset and loads on its own enable.
module reg_file_entry #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wd,
    output logic [DATA_WIDTH-1:0] q
);

    // Reset wins over a simultaneous write, so the write is lost.
    always_ff @(posedge clk) begin
        if (reset)      q <= '0;
        else if (wr_en) q <= wd;
    end

endmodule

module reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we3,
    input  logic [ADDR_WIDTH-1:0] wa3,
    input  logic [DATA_WIDTH-1:0] wd3,
    input  logic [ADDR_WIDTH-1:0] ra1,
    output logic [DATA_WIDTH-1:0] rd1,
    input  logic [ADDR_WIDTH-1:0] ra2,
    output logic [DATA_WIDTH-1:0] rd2
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef struct packed {
        logic                  en;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wr_req_t;

    wr_req_t                          wr;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] regs;

    assign wr.en   = we3;
    assign wr.addr = wa3;
    assign wr.data = wd3;

    // Entry 0 has no storage, so a write to address 0 simply vanishes.
    assign regs[0] = '0;

    genvar i;
    generate
        for (i = 1; i < DEPTH; i++) begin : g_entry
            reg_file_entry #(
                .DATA_WIDTH(DATA_WIDTH)
            ) u_entry (
                .clk  (clk),
                .reset(reset),
                .wr_en(wr.en && (wr.addr == ADDR_WIDTH'(i))),
                .wd   (wr.data),
                .q    (regs[i])
            );
        end
    endgenerate

    // Read port 1: stored word, optionally overridden by the in-flight write.
    always_comb begin
        rd1 = regs[ra1];
`ifdef REG_FILE_BYPASS_EN
        if (wr.en && !reset && (wr.addr != '0) && (wr.addr == ra1))
            rd1 = wr.data;
`endif
    end

    // Read port 2: same rules as port 1, fully independent address.
    always_comb begin
        rd2 = regs[ra2];
`ifdef REG_FILE_BYPASS_EN
        if (wr.en && !reset && (wr.addr != '0) && (wr.addr == ra2))
            rd2 = wr.data;
`endif
    end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: scoreboard bench for reg_file. Stimulus drives on the falling
// edge, predicts both read ports from an array model and queues the
// prediction; a monitor samples the ports before the next rising edge.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we3 = 1'b0;
    logic [4:0]  wa3 = '0;
    logic [31:0] wd3 = '0;
    logic [4:0]  ra1 = '0;
    logic [4:0]  ra2 = '0;
    logic [31:0] rd1;
    logic [31:0] rd2;

    reg_file dut (
        .clk  (clk),
        .reset(reset),
        .we3  (we3),
        .wa3  (wa3),
        .wd3  (wd3),
        .ra1  (ra1),
        .rd1  (rd1),
        .ra2  (ra2),
        .rd2  (rd2)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] e1;
        logic [31:0] e2;
    } exp_t;

    exp_t        exp_q[$];
    event        smp;
    logic [31:0] mem [32];
    bit          model_valid = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_pushed = 0;
    int          n_popped = 0;

    // What a read port must show in the current cycle, from the stored model
    // plus (in the bypass build) the write presented this cycle.
    function automatic logic [31:0] expect_rd(input logic [4:0] ra);
        if (ra == 5'd0) return 32'h0;
`ifdef REG_FILE_BYPASS_EN
        if (we3 && !reset && wa3 != 5'd0 && wa3 == ra) return wd3;
`endif
        return mem[ra];
    endfunction

    task automatic cyc(input logic rst, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] a1,
                       input logic [4:0] a2, input string nm);
        exp_t e;
        @(negedge clk);
        reset = rst; we3 = we; wa3 = wa; wd3 = wd; ra1 = a1; ra2 = a2;
        #2;
        if (model_valid) begin
            e.name = nm;
            e.e1   = expect_rd(a1);
            e.e2   = expect_rd(a2);
            exp_q.push_back(e);
            n_pushed++;
            -> smp;
        end
        // Effect of the coming rising edge on the model.
        if (rst) begin
            for (int k = 0; k < 32; k++) mem[k] = 32'h0;
            model_valid = 1'b1;
        end else if (we && wa != 5'd0) begin
            mem[wa] = wd;
        end
    endtask

    // Monitor: pop one prediction per sample and compare both ports.
    initial begin
        exp_t e;
        forever begin
            @(smp);
            if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_sample: no prediction queued at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                n_popped++;
                n_checks++;
                if (rd1 !== e.e1) begin
                    n_fail++;
                    $display("FAIL %s rd1: got %h expected %h (ra1=%0d)", e.name, rd1, e.e1, ra1);
                end
                n_checks++;
                if (rd2 !== e.e2) begin
                    n_fail++;
                    $display("FAIL %s rd2: got %h expected %h (ra2=%0d)", e.name, rd2, e.e2, ra2);
                end
            end
        end
    end

    initial begin
        logic        r, w;
        logic [4:0]  a, b, c;
        logic [31:0] d;

        for (int k = 0; k < 32; k++) mem[k] = 32'hx;

        // Single reset edge, then every address reads zero on both ports.
        cyc(1, 0, 0, 0, 0, 0, "reset");
        for (int k = 0; k < 32; k++)
            cyc(0, 0, 0, 0, 5'(k), 5'(31 - k), "reset_sweep");

        // Basic write and read back.
        cyc(0, 1, 5, 32'hDEADBEEF, 0, 0, "wr5");
        cyc(0, 0, 0, 0, 5, 0, "rd5");
        // Overwrite while reading the same address (old vs bypassed value).
        cyc(0, 1, 5, 32'hCAFEBABE, 5, 5, "wr5_same_cycle");
        cyc(0, 0, 0, 0, 5, 5, "rd5_after");
        // Write to address 0 is dropped.
        cyc(0, 1, 0, 32'hFFFFFFFF, 0, 0, "wr0");
        cyc(0, 0, 0, 0, 0, 5, "rd0");
        for (int k = 0; k < 32; k++)
            cyc(0, 0, 0, 0, 5'(k), 5'(k), "post_wr0_sweep");
        // Independent ports and identical addresses.
        cyc(0, 1, 7, 32'h12345678, 0, 0, "wr7");
        cyc(0, 1, 9, 32'h87654321, 7, 0, "wr9");
        cyc(0, 0, 0, 0, 7, 9, "rd7_9");
        cyc(0, 0, 0, 0, 9, 9, "rd9_9");
        // Reset beats a simultaneous write.
        cyc(1, 1, 3, 32'hAAAAAAAA, 3, 5, "reset_vs_wr");
        cyc(0, 0, 0, 0, 3, 5, "rd3_5_after_reset");
        cyc(0, 0, 0, 0, 7, 9, "rd7_9_after_reset");

        // Randomized traffic with occasional resets; addresses biased to a
        // small set so writes and reads collide often.
        for (int n = 0; n < 600; n++) begin
            r = ($urandom_range(0, 59) == 0);
            w = ($urandom_range(0, 2) != 0);
            a = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            b = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            c = ($urandom_range(0, 3) == 0) ? b : 5'($urandom_range(0, 31));
            d = $urandom;
            cyc(r, w, a, d, b, c, "random");
        end

        // Drain the scoreboard with a bounded wait.
        we3 = 1'b0;
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0 || n_popped != n_pushed) begin
            n_fail++;
            $display("FAIL drain: popped %0d expected %0d", n_popped, n_pushed);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
